// File: rtl/cabac_debinari_qp_pkg.sv
// Shared CABAC constants for cu_qp_delta de-binarisation: FSM states, TU/EG limits,
// QP modulus and legal delta range, prefix context indices.
package cabac_debinari_qp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_EGP  = 3'd2,
    ST_EGS  = 3'd3,
    ST_SIGN = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [2:0]        TU_CMAX   = 3'd5;
  localparam logic [2:0]        EG_KMAX   = 3'd4;
  localparam int                EG_SFX_W  = 4;
  localparam logic [7:0]        QP_MOD    = 8'd52;
  localparam logic signed [6:0] QP_MIN    = -7'sd26;
  localparam logic signed [6:0] QP_MAX    = 7'sd25;
  localparam logic              CTX_FIRST = 1'b0;
  localparam logic              CTX_REST  = 1'b1;

  // Magnitude of an escaped delta: TU cutoff + EG0 prefix offset + suffix.
  function automatic logic [5:0] eg_abs(input logic [2:0] k, input logic [EG_SFX_W-1:0] sfx);
    return {3'b000, TU_CMAX} + ((6'd1 << k) - 6'd1) + {2'b00, sfx};
  endfunction

endpackage

// File: rtl/cabac_debinari_qp_if.sv
// Bin handshake and result bus between the arithmetic decoder side and the QP de-binariser.
interface cabac_debinari_qp_if;
  logic       start_i;
  logic [5:0] cu_last_qp_i;
  logic       bin_valid_i;
  logic       bin_i;
  logic       bin_ready_o;
  logic       bin_bypass_o;
  logic       bin_ctx_idx_o;
  logic       done_o;
  logic [6:0] cu_dqp_o;
  logic [5:0] cu_curr_qp_o;
  logic       error_o;

  modport slave (
    input  start_i, cu_last_qp_i, bin_valid_i, bin_i,
    output bin_ready_o, bin_bypass_o, bin_ctx_idx_o, done_o, cu_dqp_o, cu_curr_qp_o, error_o
  );

  modport master (
    output start_i, cu_last_qp_i, bin_valid_i, bin_i,
    input  bin_ready_o, bin_bypass_o, bin_ctx_idx_o, done_o, cu_dqp_o, cu_curr_qp_o, error_o
  );
endinterface

// File: rtl/cabac_debinari_qp_wrap.sv
// QP reconstruction: (last + dqp + 52) mod 52 with two conditional subtractions,
// valid for last in 0..51 and dqp in -35..+35.
module cabac_debinari_qp_wrap
  import cabac_debinari_qp_pkg::*;
(
  input  logic [5:0] i_last_qp,
  input  logic [6:0] i_dqp,
  output logic [5:0] o_qp
);
  logic [7:0] w_sum;
  logic [7:0] w_s1;

  // Biased sum lies in 17..138, so 8-bit unsigned arithmetic is exact.
  assign w_sum = {2'b00, i_last_qp} + {i_dqp[6], i_dqp} + QP_MOD;
  assign w_s1  = (w_sum >= QP_MOD) ? (w_sum - QP_MOD) : w_sum;
  assign o_qp  = (w_s1 >= QP_MOD) ? 6'(w_s1 - QP_MOD) : 6'(w_s1);
endmodule

// File: rtl/cabac_debinari_qp.sv
// cu_qp_delta de-binariser: TU prefix (cMax 5) + EG0 escape + sign, then QP reconstruction.
module cabac_debinari_qp
  import cabac_debinari_qp_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  cabac_debinari_qp_if.slave bus
);
  state_t              r_state, w_state_next;
  logic [2:0]          r_pre_cnt, w_pre_cnt_next;
  logic [2:0]          r_k, w_k_next;
  logic [2:0]          r_sfx_cnt, w_sfx_cnt_next;
  logic [EG_SFX_W-2:0] r_sfx, w_sfx_next;
  logic [5:0]          r_abs, w_abs_next;
  logic                r_neg, w_neg_next;
  logic                r_ovf, w_ovf_next;
  logic [5:0]          r_last_qp, w_last_qp_next;

  logic                w_take;
  logic [EG_SFX_W-1:0] w_sfx_shift;
  logic [6:0]          w_dqp;
  logic                w_range_err;
  logic [5:0]          w_curr_qp;

  assign w_take      = bus.bin_valid_i && bus.bin_ready_o;
  assign w_sfx_shift = {r_sfx, bus.bin_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pre_cnt <= '0;
      r_k       <= '0;
      r_sfx_cnt <= '0;
      r_sfx     <= '0;
      r_abs     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_last_qp <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pre_cnt <= w_pre_cnt_next;
      r_k       <= w_k_next;
      r_sfx_cnt <= w_sfx_cnt_next;
      r_sfx     <= w_sfx_next;
      r_abs     <= w_abs_next;
      r_neg     <= w_neg_next;
      r_ovf     <= w_ovf_next;
      r_last_qp <= w_last_qp_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pre_cnt_next = r_pre_cnt;
    w_k_next       = r_k;
    w_sfx_cnt_next = r_sfx_cnt;
    w_sfx_next     = r_sfx;
    w_abs_next     = r_abs;
    w_neg_next     = r_neg;
    w_ovf_next     = r_ovf;
    w_last_qp_next = r_last_qp;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_last_qp_next = bus.cu_last_qp_i;
          w_pre_cnt_next = '0;
          w_k_next       = '0;
          w_sfx_cnt_next = '0;
          w_sfx_next     = '0;
          w_abs_next     = '0;
          w_neg_next     = 1'b0;
          w_ovf_next     = 1'b0;
          w_state_next   = ST_PRE;
        end
      end
      ST_PRE: begin
        if (w_take) begin
          if (bus.bin_i) begin
            w_pre_cnt_next = r_pre_cnt + 3'd1;
            if (r_pre_cnt == TU_CMAX - 3'd1) w_state_next = ST_EGP;
          end else begin
            w_abs_next   = {3'b000, r_pre_cnt};
            w_state_next = (r_pre_cnt == 3'd0) ? ST_DONE : ST_SIGN;
          end
        end
      end
      ST_EGP: begin
        if (w_take) begin
          if (bus.bin_i) begin
            // A fifth escape-prefix one cannot be represented: abort with error.
            if (r_k == EG_KMAX) begin
              w_ovf_next   = 1'b1;
              w_state_next = ST_DONE;
            end else begin
              w_k_next = r_k + 3'd1;
            end
          end else if (r_k == 3'd0) begin
            w_abs_next   = {3'b000, TU_CMAX};
            w_state_next = ST_SIGN;
          end else begin
            w_state_next = ST_EGS;
          end
        end
      end
      ST_EGS: begin
        if (w_take) begin
          w_sfx_next     = w_sfx_shift[EG_SFX_W-2:0];
          w_sfx_cnt_next = r_sfx_cnt + 3'd1;
          if (r_sfx_cnt + 3'd1 == r_k) begin
            w_abs_next   = eg_abs(r_k, w_sfx_shift);
            w_state_next = ST_SIGN;
          end
        end
      end
      ST_SIGN: begin
        if (w_take) begin
          w_neg_next   = bus.bin_i;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result is a pure function of held registers, so it stays put until the next start.
  assign w_dqp       = r_ovf ? 7'd0 : (r_neg ? (7'd0 - {1'b0, r_abs}) : {1'b0, r_abs});
  assign w_range_err = ($signed(w_dqp) < QP_MIN) || ($signed(w_dqp) > QP_MAX);

  cabac_debinari_qp_wrap u_wrap (
    .i_last_qp (r_last_qp),
    .i_dqp     (w_dqp),
    .o_qp      (w_curr_qp)
  );

  assign bus.bin_ready_o   = (r_state == ST_PRE) || (r_state == ST_EGP) ||
                             (r_state == ST_EGS) || (r_state == ST_SIGN);
  assign bus.bin_bypass_o  = (r_state == ST_EGP) || (r_state == ST_EGS) || (r_state == ST_SIGN);
  assign bus.bin_ctx_idx_o = ((r_state == ST_PRE) && (r_pre_cnt != 3'd0)) ? CTX_REST : CTX_FIRST;
  assign bus.done_o        = (r_state == ST_DONE);
  assign bus.cu_dqp_o      = w_dqp;
  assign bus.cu_curr_qp_o  = w_curr_qp;
  assign bus.error_o       = r_ovf || w_range_err;
endmodule

// File: tb/tb_cabac_debinari_qp.sv
// Directed bench for cabac_debinari_qp: bin-string model plus per-cycle compare process.
module tb_cabac_debinari_qp;
  logic clk;
  logic rst_n;
  cabac_debinari_qp_if bus();

  cabac_debinari_qp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expectations published by the driver for the current cycle.
  bit chk_rst   = 1'b0;
  bit in_decode = 1'b0;
  bit chk_bin   = 1'b0;
  bit exp_byp   = 1'b0;
  bit exp_ctx   = 1'b0;
  bit exp_done  = 1'b0;
  bit hold      = 1'b0;

  // Model results and hand-computed literals for the current case.
  bit m_byp [0:31];
  bit m_ctx [0:31];
  int m_n, m_dqp, m_qp, m_err;
  int lit_dqp, lit_qp, lit_err;

  task automatic model(input int last, input string bits);
    int  pos, pre, k, sfx, absv;
    bit  ovf, neg, b;
    pos = 0; pre = 0; k = 0; sfx = 0; absv = 0; ovf = 1'b0; neg = 1'b0;
    // Truncated-unary prefix of up to five context-coded ones.
    while (pre < 5 && bits.getc(pos) == "1") begin
      m_byp[pos] = 1'b0; m_ctx[pos] = (pre != 0); pre++; pos++;
    end
    if (pre < 5) begin
      m_byp[pos] = 1'b0; m_ctx[pos] = (pre != 0); pos++;
      absv = pre;
    end else begin
      forever begin
        m_byp[pos] = 1'b1; m_ctx[pos] = 1'b0;
        b = (bits.getc(pos) == "1"); pos++;
        if (!b) break;
        k++;
        if (k == 5) begin ovf = 1'b1; break; end
      end
      if (!ovf) begin
        for (int i = 0; i < k; i++) begin
          m_byp[pos] = 1'b1; m_ctx[pos] = 1'b0;
          sfx = sfx * 2 + ((bits.getc(pos) == "1") ? 1 : 0); pos++;
        end
        absv = 5 + (2 ** k) - 1 + sfx;
      end
    end
    if (!ovf && absv > 0) begin
      m_byp[pos] = 1'b1; m_ctx[pos] = 1'b0;
      neg = (bits.getc(pos) == "1"); pos++;
    end
    m_n   = pos;
    m_dqp = ovf ? 0 : (neg ? -absv : absv);
    m_err = (ovf || m_dqp < -26 || m_dqp > 25) ? 1 : 0;
    m_qp  = (last + m_dqp + 52) % 52;
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    if (chk_rst) begin
      chk("rst_ready", int'(bus.bin_ready_o), 0);
      chk("rst_done",  int'(bus.done_o), 0);
      chk("rst_err",   int'(bus.error_o), 0);
      chk("rst_dqp",   int'(bus.cu_dqp_o), 0);
      chk("rst_qp",    int'(bus.cu_curr_qp_o), 0);
    end else begin
      chk("ready", int'(bus.bin_ready_o), int'(in_decode));
      chk("done",  int'(bus.done_o), int'(exp_done));
      if (chk_bin) begin
        chk("bypass", int'(bus.bin_bypass_o), int'(exp_byp));
        if (!exp_byp) chk("ctx_idx", int'(bus.bin_ctx_idx_o), int'(exp_ctx));
      end
      if (exp_done || hold) begin
        chk("dqp", int'($signed(bus.cu_dqp_o)), m_dqp);
        chk("qp",  int'(bus.cu_curr_qp_o), m_qp);
        chk("err", int'(bus.error_o), m_err);
      end
      if (exp_done) begin
        chk("dqp_lit", int'($signed(bus.cu_dqp_o)), lit_dqp);
        chk("qp_lit",  int'(bus.cu_curr_qp_o), lit_qp);
        chk("err_lit", int'(bus.error_o), lit_err);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input int last, input string bits, input int ldqp, input int lqp,
                          input int lerr, input bit gaps, input bit poke);
    int idx, ngap;
    model(last, bits);
    lit_dqp = ldqp; lit_qp = lqp; lit_err = lerr;
    hold = 1'b0;
    bus.start_i = 1'b1; bus.cu_last_qp_i = 6'(last); bus.bin_valid_i = 1'b0;
    tick;
    bus.start_i = 1'b0; in_decode = 1'b1;
    idx = 0; ngap = 0;
    while (idx < m_n) begin
      if (gaps && ngap < 2 && $urandom_range(0, 2) == 0) begin
        ngap++;
        bus.bin_valid_i = 1'b0; bus.bin_i = 1'($urandom_range(0, 1)); chk_bin = 1'b0;
      end else begin
        ngap = 0;
        bus.bin_valid_i = 1'b1; bus.bin_i = (bits.getc(idx) == "1");
        chk_bin = 1'b1; exp_byp = m_byp[idx]; exp_ctx = m_ctx[idx];
        idx++;
      end
      // A start pulse mid-decode with a different QP must be ignored.
      if (poke && idx == 3) begin bus.start_i = 1'b1; bus.cu_last_qp_i = 6'd0; end
      else bus.start_i = 1'b0;
      tick;
    end
    bus.bin_valid_i = 1'b0; bus.start_i = 1'b0; chk_bin = 1'b0;
    in_decode = 1'b0; exp_done = 1'b1;
    tick;
    exp_done = 1'b0; hold = 1'b1;
    repeat (2) tick;
  endtask

  initial begin
    rst_n = 1'b0; chk_rst = 1'b1;
    bus.start_i = 1'b0; bus.cu_last_qp_i = 6'd0; bus.bin_valid_i = 1'b0; bus.bin_i = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1; chk_rst = 1'b0;
    tick;

    run_case(30, "0",               0, 30, 0, 1'b0, 1'b0);
    run_case(30, "11101",          -3, 27, 0, 1'b0, 1'b0);
    run_case(50, "1111100",         5,  3, 0, 1'b0, 1'b0);
    run_case(10, "1111111100000",  12, 22, 0, 1'b0, 1'b0);
    run_case(10, "1111111100000",  12, 22, 0, 1'b1, 1'b1);
    run_case(17, "1111111111",      0, 17, 1, 1'b0, 1'b0);
    run_case(40, "111111111001110", 27, 15, 1, 1'b0, 1'b0);
    run_case(5,  "111111111001101", -26, 31, 0, 1'b0, 1'b0);
    run_case(5,  "111111111001111", -27, 30, 1, 1'b0, 1'b0);
    run_case(51, "111111111001010", 25, 24, 0, 1'b1, 1'b0);
    run_case(0,  "111101",         -4, 48, 0, 1'b0, 1'b0);
    run_case(3,  "111111011",      -7, 48, 0, 1'b1, 1'b0);

    // Reset in the middle of a prefix, then decode again.
    hold = 1'b0;
    bus.start_i = 1'b1; bus.cu_last_qp_i = 6'd20;
    tick;
    bus.start_i = 1'b0; in_decode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.bin_valid_i = 1'b1; bus.bin_i = 1'b1;
      chk_bin = 1'b1; exp_byp = 1'b0; exp_ctx = (i != 0);
      tick;
    end
    bus.bin_valid_i = 1'b0; chk_bin = 1'b0; in_decode = 1'b0;
    rst_n = 1'b0; chk_rst = 1'b1;
    repeat (2) tick;
    rst_n = 1'b1; chk_rst = 1'b0;
    tick;
    run_case(20, "1100",            2, 22, 0, 1'b0, 1'b0);

    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
